move_scheduler: RTL

MOVE_SCHEDULER -- requirements
Module: move_scheduler

---
 rtl/snake_pkg.sv | 34 +++
 rtl/move_scheduler_if.sv | 32 +++
 rtl/dir_queue.sv | 66 ++++++
 rtl/move_scheduler.sv | 122 ++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared snake-game definitions: one-hot direction codes, scheduler state
// encodings and direction helpers used by both the scheduler and the keyboard decoder.
package snake_pkg;

    localparam logic [4:0] DIR_RIGHT = 5'b00001;
    localparam logic [4:0] DIR_DOWN  = 5'b00010;
    localparam logic [4:0] DIR_LEFT  = 5'b00100;
    localparam logic [4:0] DIR_UP    = 5'b01000;
    localparam logic [4:0] DIR_NONE  = 5'b10000;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_RUN    = 2'b01;
    localparam logic [1:0] ST_PAUSED = 2'b10;
    localparam logic [1:0] ST_OVER   = 2'b11;

    // NONE and any illegal code have no opposite, so they map to NONE.
    function automatic logic [4:0] dirOpposite(input logic [4:0] dir);
        logic [4:0] result;
        case (dir)
            DIR_RIGHT: result = DIR_LEFT;
            DIR_LEFT:  result = DIR_RIGHT;
            DIR_UP:    result = DIR_DOWN;
            DIR_DOWN:  result = DIR_UP;
            default:   result = DIR_NONE;
        endcase
        return result;
    endfunction

    function automatic logic isSingleDir(input logic [4:0] dir);
        return (dir == DIR_RIGHT) || (dir == DIR_DOWN) ||
               (dir == DIR_LEFT)  || (dir == DIR_UP);
    endfunction

endpackage

// File: rtl/move_scheduler_if.sv
// Handshake bundle between the game logic / keyboard decoder and the move scheduler.
interface move_scheduler_if;

    logic [4:0] dir_in;
    logic       pause;
    logic       collision;
    logic       restart;
    logic [4:0] move_dir;
    logic       move_stb;
    logic [1:0] state;

    modport master (
        output dir_in,
        output pause,
        output collision,
        output restart,
        input  move_dir,
        input  move_stb,
        input  state
    );

    modport slave (
        input  dir_in,
        input  pause,
        input  collision,
        input  restart,
        output move_dir,
        output move_stb,
        output state
    );

endinterface

// File: rtl/dir_queue.sv
// Two-entry FIFO of pending direction changes with push/pop/flush and head/tail peeks.
module dir_queue
    import snake_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_push,
    input  logic [4:0] i_pushData,
    input  logic       i_pop,
    input  logic       i_flush,
    output logic [4:0] o_head,
    output logic [4:0] o_tail,
    output logic       o_full,
    output logic       o_empty
);

    logic [4:0] r_mem0;
    logic [4:0] r_mem1;
    logic [1:0] r_count;
    logic       w_doPop;
    logic       w_doPush;

    // A push into a full queue only lands when a pop frees a slot in the same cycle.
    assign w_doPop  = i_pop && (r_count != 2'd0);
    assign w_doPush = i_push && ((r_count != 2'd2) || w_doPop);

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_count <= 2'd0;
            r_mem0  <= DIR_NONE;
            r_mem1  <= DIR_NONE;
        end else begin
            case ({w_doPush, w_doPop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_mem0 <= i_pushData;
                    end else begin
                        r_mem1 <= i_pushData;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_mem0  <= r_mem1;
                    r_mem1  <= DIR_NONE;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_mem0 <= i_pushData;
                    end else begin
                        r_mem0 <= r_mem1;
                        r_mem1 <= i_pushData;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_head  = r_mem0;
    assign o_tail  = (r_count == 2'd2) ? r_mem1 : r_mem0;
    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);

endmodule

// File: rtl/move_scheduler.sv
// Snake move scheduler: filters keyboard direction changes, queues up to two of them,
// and issues a one-cycle move strobe every STEP_CYCLES clocks while the game runs.
module move_scheduler
    import snake_pkg::*;
#(
    parameter int STEP_CYCLES = 6_500_000,
    parameter int CNT_W       = 23
) (
    input  logic               clk,
    input  logic               reset,
    move_scheduler_if.slave    bus
);

    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    logic [1:0]       r_state;
    logic [4:0]       r_moveDir;
    logic             r_moveStb;
    logic [CNT_W-1:0] r_count;
    logic [4:0]       r_dirPrev;

    logic [4:0] w_qHead;
    logic [4:0] w_qTail;
    logic       w_qFull;
    logic       w_qEmpty;
    logic       w_request;
    logic [4:0] w_refDir;
    logic       w_accept;
    logic       w_inGame;
    logic       w_stepping;
    logic       w_terminal;
    logic       w_push;
    logic       w_pop;
    logic       w_flush;

    // Request filtering uses the pre-pop tail so a push racing a pop is judged
    // against the direction the snake will be travelling when the push is consumed.
    always_comb begin
        w_request  = (bus.dir_in != r_dirPrev) && isSingleDir(bus.dir_in);
        w_refDir   = w_qEmpty ? r_moveDir : w_qTail;
        w_accept   = w_request && (bus.dir_in != w_refDir) &&
                     (bus.dir_in != dirOpposite(w_refDir));
        w_inGame   = (r_state == ST_RUN) || (r_state == ST_PAUSED);
        w_stepping = w_inGame && !bus.collision && !bus.pause;
        w_terminal = w_stepping && (r_count == CNT_TERM);
        w_pop      = w_terminal && !w_qEmpty;
        w_push     = w_stepping && w_accept;
        w_flush    = w_inGame && bus.collision;
    end

    dir_queue u_dirQueue (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_push),
        .i_pushData (bus.dir_in),
        .i_pop      (w_pop),
        .i_flush    (w_flush),
        .o_head     (w_qHead),
        .o_tail     (w_qTail),
        .o_full     (w_qFull),
        .o_empty    (w_qEmpty)
    );

    // Releasing pause counts in the same cycle, so a period resumes exactly where it stopped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_moveDir <= DIR_NONE;
            r_moveStb <= 1'b0;
            r_count   <= CNT_ZERO;
            r_dirPrev <= DIR_NONE;
        end else begin
            r_dirPrev <= bus.dir_in;
            r_moveStb <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_moveDir <= bus.dir_in;
                        r_count   <= CNT_ZERO;
                        r_state   <= ST_RUN;
                    end
                end
                ST_RUN, ST_PAUSED: begin
                    if (bus.collision) begin
                        r_state <= ST_OVER;
                        r_count <= CNT_ZERO;
                    end else if (bus.pause) begin
                        r_state <= ST_PAUSED;
                    end else begin
                        r_state <= ST_RUN;
                        if (w_terminal) begin
                            r_count   <= CNT_ZERO;
                            r_moveStb <= !r_moveStb;
                            if (w_pop) begin
                                r_moveDir <= w_qHead;
                            end
                        end else begin
                            r_count <= r_count + CNT_ONE;
                        end
                    end
                end
                ST_OVER: begin
                    if (bus.restart) begin
                        r_state   <= ST_IDLE;
                        r_moveDir <= DIR_NONE;
                        r_count   <= CNT_ZERO;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.move_dir = r_moveDir;
    assign bus.move_stb = r_moveStb;
    assign bus.state    = r_state;

endmodule
